// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Owns the PC, issues sequential word reads to a
// fixed-latency instruction memory, buffers the returned words in a small skid
// FIFO and offers them to the instruction queue over valid/ready. A redirect
// restarts fetch at a new PC and discards every in-flight and buffered word.
//
// Ports:
//   clk_in              system clock
//   rst_n_in            asynchronous active-low reset
//   imem_req_out        instruction memory read enable
//   imem_addr_out       word-aligned byte address of the read
//   imem_data_in        read data, MEM_LATENCY cycles after the request
//   iq_ready_in         instruction queue can accept
//   iq_valid_out        instruction word offered to the queue
//   iq_instruction_out  offered instruction word (FIFO head)
//   iq_pc_out           PC of the offered instruction word
//   redirect_in         one-cycle flush/restart pulse
//   redirect_pc_in      restart PC, bits [1:0] ignored
//   pc_out              next PC to be requested
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2,
  parameter int          BUF_DEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  input  logic        iq_ready_in,
  output logic        iq_valid_out,
  output logic [31:0] iq_instruction_out,
  output logic [31:0] iq_pc_out,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] pc_out
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int IFL_W = $clog2(MEM_LATENCY + 1);
  localparam int SUM_W = ((CNT_W > IFL_W) ? CNT_W : IFL_W) + 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             run_reg;       // low until the first edge after reset release
  logic [31:0]      pc_reg;
  logic             epoch_reg;

  // Request tracking pipe, slot 0 is the newest request.
  logic             slot_valid_reg [MEM_LATENCY];
  logic             slot_epoch_reg [MEM_LATENCY];
  logic             slot_stale_reg [MEM_LATENCY];
  logic [31:0]      slot_pc_reg    [MEM_LATENCY];
  logic [IFL_W-1:0] inflight_reg;

  // Skid FIFO
  logic [31:0]      fifo_instr_mem [BUF_DEPTH];
  logic [31:0]      fifo_pc_mem    [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] credit_sum;
  logic             credit_ok;
  logic             exit_valid;
  logic             exit_current;
  logic             push_en;
  logic             pop_en;
  logic             fifo_nonempty;
  logic [31:0]      redirect_pc_aligned;

  // Credits count every outstanding pipe slot (stale ones included) plus every
  // buffered word, so a response always has a FIFO entry waiting for it.
  assign credit_sum   = SUM_W'(inflight_reg) + SUM_W'(count_reg);
  assign credit_ok    = credit_sum < SUM_W'(BUF_DEPTH);
  assign imem_req_out = run_reg && !redirect_in && credit_ok;
  assign imem_addr_out = pc_reg;
  assign pc_out        = pc_reg;

  assign exit_valid = slot_valid_reg[MEM_LATENCY-1];

  // The stale flag makes the epoch compare exact even if the one-bit epoch has
  // toggled back to its old value through several redirects.
  assign exit_current = !slot_stale_reg[MEM_LATENCY-1] &&
                        (slot_epoch_reg[MEM_LATENCY-1] == epoch_reg);
  assign push_en      = exit_valid && exit_current && !redirect_in;

  assign fifo_nonempty      = (count_reg != '0);
  assign iq_valid_out       = fifo_nonempty && !redirect_in;
  assign pop_en             = iq_valid_out && iq_ready_in;
  assign iq_instruction_out = fifo_nonempty ? fifo_instr_mem[rd_ptr_reg] : 32'h0;
  assign iq_pc_out          = fifo_nonempty ? fifo_pc_mem[rd_ptr_reg]    : 32'h0;

  assign redirect_pc_aligned = redirect_pc_in & 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------------
  // PC, epoch and start-up
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_reg   <= 1'b0;
      pc_reg    <= RESET_PC;
      epoch_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (redirect_in) begin
        pc_reg    <= redirect_pc_aligned;
        epoch_reg <= ~epoch_reg;
      end else if (imem_req_out) begin
        pc_reg <= pc_reg + 32'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request tracking pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        slot_valid_reg[i] <= 1'b0;
        slot_epoch_reg[i] <= 1'b0;
        slot_stale_reg[i] <= 1'b0;
        slot_pc_reg[i]    <= 32'h0;
      end
    end else begin
      // No request is issued in a redirect cycle, so the new slot is never stale.
      slot_valid_reg[0] <= imem_req_out;
      slot_epoch_reg[0] <= epoch_reg;
      slot_stale_reg[0] <= 1'b0;
      slot_pc_reg[0]    <= pc_reg;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        slot_valid_reg[i] <= slot_valid_reg[i-1];
        slot_epoch_reg[i] <= slot_epoch_reg[i-1];
        slot_stale_reg[i] <= slot_stale_reg[i-1] | redirect_in;
        slot_pc_reg[i]    <= slot_pc_reg[i-1];
      end
    end
  end

  // Stale slots keep their credit until they leave the pipe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_reg + IFL_W'(imem_req_out) - IFL_W'(exit_valid);
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (push_en) begin
      fifo_instr_mem[wr_ptr_reg] <= imem_data_in;
      fifo_pc_mem[wr_ptr_reg]    <= slot_pc_reg[MEM_LATENCY-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_in) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // The credit rule must never allow a push into a full FIFO.
  assert property (@(posedge clk_in) disable iff (!rst_n_in)
                   !(push_en && !pop_en && (count_reg == CNT_FULL)));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A memory model answers every read with addr^PATTERN
// MEM_LATENCY cycles later. The expected instruction stream is a queue of
// sequential PCs restarted at every reset/redirect; a monitor pops it on every
// accepted queue write and also checks latency and credit bounds.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          L        = 2;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] PAT      = 32'hA5A5_0000;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;
  logic        iq_ready_in;
  logic        iq_valid_out;
  logic [31:0] iq_instruction_out;
  logic [31:0] iq_pc_out;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] pc_out;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .MEM_LATENCY(L),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .imem_req_out      (imem_req_out),
    .imem_addr_out     (imem_addr_out),
    .imem_data_in      (imem_data_in),
    .iq_ready_in       (iq_ready_in),
    .iq_valid_out      (iq_valid_out),
    .iq_instruction_out(iq_instruction_out),
    .iq_pc_out         (iq_pc_out),
    .redirect_in       (redirect_in),
    .redirect_pc_in    (redirect_pc_in),
    .pc_out            (pc_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: data for the address requested L cycles earlier
  // ---------------------------------------------------------------------------
  logic [31:0] addr_pipe [L];

  always @(negedge clk_in) begin
    for (int i = L - 1; i > 0; i--) addr_pipe[i] = addr_pipe[i-1];
    addr_pipe[0] = imem_addr_out;
  end

  always @(posedge clk_in) begin
    #1 imem_data_in = addr_pipe[L-1] ^ PAT;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: expected PCs of the words the queue will receive
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;

  int first_req_cyc;
  bit first_valid_done;
  int redir_cyc;
  bit redir_armed;
  bit redir_req_armed;
  int outstanding;
  int idle_ready;

  function automatic void reset_expect(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 32'(4 * i));
    exp_tail = start + 32'd60;
  endfunction

  task automatic restart_tracking(input logic [31:0] start);
    reset_expect(start);
    first_req_cyc    = -1;
    first_valid_done = 1'b0;
    redir_armed      = 1'b0;
    redir_req_armed  = 1'b0;
    outstanding      = 0;
    idle_ready       = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (redirect_in) begin
        check("valid_in_redirect_cycle", 32'(iq_valid_out), 32'd0);
        check("req_in_redirect_cycle", 32'(imem_req_out), 32'd0);
        redir_cyc       = cyc;
        redir_armed     = 1'b1;
        redir_req_armed = 1'b1;
        outstanding     = 0;
        idle_ready      = 0;
      end else begin
        bit pop;
        pop = iq_valid_out && iq_ready_in;

        if (redir_req_armed && cyc == redir_cyc + 1) begin
          check("req_cycle_after_redirect", 32'(imem_req_out), 32'd1);
          redir_req_armed = 1'b0;
        end
        if (redir_armed && iq_valid_out) begin
          check("redirect_to_valid_latency", 32'(cyc - redir_cyc), 32'(L + 2));
          redir_armed = 1'b0;
        end
        if (first_req_cyc < 0 && imem_req_out) first_req_cyc = cyc;
        if (!first_valid_done && iq_valid_out) begin
          check("reset_req_to_valid_latency", 32'(cyc - first_req_cyc), 32'(L + 1));
          first_valid_done = 1'b1;
        end
        if (imem_req_out) check("addr_word_aligned", 32'(imem_addr_out[1:0]), 32'd0);

        if (pop) begin
          logic [31:0] e;
          if (exp_q.size() == 0) begin
            check("scoreboard_empty_on_pop", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            exp_tail = exp_tail + 32'd4;
            exp_q.push_back(exp_tail);
            $display("cycle %0d: queue write pc=0x%08h instr=0x%08h", cyc, iq_pc_out, iq_instruction_out);
            check("iq_pc_out", iq_pc_out, e);
            check("iq_instruction_out", iq_instruction_out, e ^ PAT);
          end
        end

        outstanding = outstanding + (imem_req_out ? 1 : 0) - (pop ? 1 : 0);
        check("credit_bound", 32'(outstanding <= DEPTH), 32'd1);

        if (iq_ready_in && !pop) idle_ready++;
        else idle_ready = 0;
        if (idle_ready >= 16) begin
          check("progress_watchdog", 32'(idle_ready), 32'd0);
          idle_ready = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Called at posedge+1; holds the pulse for exactly one cycle.
  task automatic do_redirect(input logic [31:0] target);
    redirect_in    = 1'b1;
    redirect_pc_in = target;
    reset_expect(target & 32'hFFFF_FFFC);
    @(posedge clk_in);
    #1 redirect_in = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n_in       = 1'b0;
    iq_ready_in    = 1'b1;
    redirect_in    = 1'b0;
    redirect_pc_in = 32'h0;
    imem_data_in   = 32'h0;
    for (int i = 0; i < L; i++) addr_pipe[i] = 32'h0;
    restart_tracking(RESET_PC);

    // Reset state
    repeat (3) @(posedge clk_in);
    #2;
    check("reset_iq_valid_out", 32'(iq_valid_out), 32'd0);
    check("reset_imem_req_out", 32'(imem_req_out), 32'd0);
    check("reset_pc_out", pc_out, RESET_PC);
    check("reset_imem_addr_out", imem_addr_out, RESET_PC);
    check("reset_iq_instruction_out", iq_instruction_out, 32'h0);
    check("reset_iq_pc_out", iq_pc_out, 32'h0);
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;

    // Free-running stream
    repeat (20) @(posedge clk_in);

    // Backpressure for 10 cycles
    #1 iq_ready_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    check("stall_req_stopped", 32'(imem_req_out), 32'd0);
    check("stall_outstanding_full", 32'(outstanding), 32'(DEPTH));
    check("stall_valid_held", 32'(iq_valid_out), 32'd1);
    iq_ready_in = 1'b1;
    repeat (10) @(posedge clk_in);

    // Redirect to 0x100 with words in flight and buffered
    #1 iq_ready_in = 1'b0;
    @(posedge clk_in);
    #1 iq_ready_in = 1'b1;
    do_redirect(32'h0000_0100);
    repeat (10) @(posedge clk_in);

    // Redirect while a word is being accepted; unaligned target
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk_in);
      #1 found = iq_valid_out;
    end
    check("valid_before_redirect", 32'(found), 32'd1);
    do_redirect(32'h0000_0203);
    repeat (10) @(posedge clk_in);

    // Wrap-around target
    #1 do_redirect(32'hFFFF_FFFC);
    repeat (10) @(posedge clk_in);

    // Randomized traffic with random redirects
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk_in);
      #1 iq_ready_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       do_redirect($urandom);
          1:       do_redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
          default: do_redirect(32'($urandom_range(0, 255)));
        endcase
      end
    end
    iq_ready_in = 1'b1;
    repeat (10) @(posedge clk_in);

    // Asynchronous reset between edges
    #3 rst_n_in = 1'b0;
    #1;
    check("async_reset_iq_valid_out", 32'(iq_valid_out), 32'd0);
    check("async_reset_imem_req_out", 32'(imem_req_out), 32'd0);
    check("async_reset_pc_out", pc_out, RESET_PC);
    restart_tracking(RESET_PC);
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    repeat (20) @(posedge clk_in);
    #1;
    check("restart_first_valid_seen", 32'(first_valid_done), 32'd1);
    check("restart_stream_advanced", 32'(exp_q[0] != RESET_PC), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
